// File: rtl/cop0_interrupt_source.sv
// COP0 interrupt source: Count/Compare timer, external-pin synchronizers and
// edge latches feeding the registered hardware_int vector.
module cop0_interrupt_source #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [5:0] EDGE_MASK   = 6'b000000,
   parameter int         TIMER_LINE  = 5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [5:0]  ext_int_raw,
   input  logic        accept_hardware_interrupt,
   input  logic [5:0]  ext_int_taken,
   input  logic        count_dc,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] cop0_wdata,
   output logic [5:0]  hardware_int,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_pending
);

   generate
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
         $error("SYNC_STAGES must be in 2..4");
      end
      if (TIMER_LINE < 0 || TIMER_LINE > 5) begin : g_bad_timer
         $error("TIMER_LINE must be in 0..5");
      end
   endgenerate

   logic [SYNC_STAGES-1:0][5:0] r_sync;
   logic [5:0]  r_prev;
   logic [5:0]  r_pend;
   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic        r_tog;
   logic        r_timer_pending;

   logic [5:0]  w_synced;
   logic [5:0]  w_set;
   logic [5:0]  w_clr;
   logic [5:0]  w_line;
   logic [5:0]  w_timer_vec;
   logic [31:0] w_count_plus1;
   logic        w_inc;
   logic        w_match;

   // Pins are asynchronous: shift each through its own flop chain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], ext_int_raw};
      end
   end

   assign w_synced = r_sync[SYNC_STAGES-1];
   assign w_set    = w_synced & ~r_prev & EDGE_MASK;
   assign w_clr    = {6{accept_hardware_interrupt}} & ext_int_taken;

   // Set beats clear so a new edge arriving on the acknowledge cycle is kept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev <= '0;
         r_pend <= '0;
      end else begin
         r_prev <= w_synced;
         r_pend <= (w_set | (r_pend & ~w_clr)) & EDGE_MASK;
      end
   end

   assign w_count_plus1 = r_count + 32'd1;
   assign w_inc         = !count_we && !count_dc && r_tog;
   assign w_match       = w_inc && (w_count_plus1 == r_compare);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count         <= '0;
         r_tog           <= 1'b0;
         r_compare       <= '0;
         r_timer_pending <= 1'b0;
      end else begin
         if (count_we) begin
            r_count <= cop0_wdata;
            r_tog   <= 1'b0;
         end else if (!count_dc) begin
            r_tog <= ~r_tog;
            if (r_tog) begin
               r_count <= w_count_plus1;
            end
         end
         if (compare_we) begin
            r_compare <= cop0_wdata;
         end
         if (compare_we) begin
            r_timer_pending <= 1'b0;
         end else if (w_match) begin
            r_timer_pending <= 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_line
         if (EDGE_MASK[gi]) begin : g_edge
            assign w_line[gi] = r_pend[gi];
         end else begin : g_level
            assign w_line[gi] = w_synced[gi];
         end
      end
   endgenerate

   assign w_timer_vec   = r_timer_pending ? (6'b000001 << TIMER_LINE) : 6'b000000;
   assign hardware_int  = w_line | w_timer_vec;
   assign count         = r_count;
   assign compare       = r_compare;
   assign timer_pending = r_timer_pending;

endmodule

// File: tb/tb_cop0_interrupt_source.sv
// Bench for cop0_interrupt_source: directed scenarios with literal expectations
// followed by randomized traffic, all checked against a behavioural model.
module tb_cop0_interrupt_source;

   localparam int         SYNC = 2;
   localparam logic [5:0] MASK = 6'b001011;
   localparam int         TL   = 5;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [5:0]  ext_int_raw = '0;
   logic        accept_hardware_interrupt = 1'b0;
   logic [5:0]  ext_int_taken = '0;
   logic        count_dc = 1'b0;
   logic        count_we = 1'b0;
   logic        compare_we = 1'b0;
   logic [31:0] cop0_wdata = '0;
   logic [5:0]  hardware_int;
   logic [31:0] count;
   logic [31:0] compare;
   logic        timer_pending;

   cop0_interrupt_source #(.SYNC_STAGES(SYNC), .EDGE_MASK(MASK), .TIMER_LINE(TL)) dut (
      .clk                       (clk),
      .reset_n                   (reset_n),
      .ext_int_raw               (ext_int_raw),
      .accept_hardware_interrupt (accept_hardware_interrupt),
      .ext_int_taken             (ext_int_taken),
      .count_dc                  (count_dc),
      .count_we                  (count_we),
      .compare_we                (compare_we),
      .cop0_wdata                (cop0_wdata),
      .hardware_int              (hardware_int),
      .count                     (count),
      .compare                   (compare),
      .timer_pending             (timer_pending)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: pin samples newest-first, so the synchronized view is simply
   // the sample taken SYNC-1 edges back.
   logic [5:0]  s_hist [0:7];
   logic [5:0]  m_pend;
   logic [31:0] m_count;
   logic [31:0] m_compare;
   int          m_ticks;
   logic        m_tp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 8; k++) s_hist[k] = '0;
      m_pend    = '0;
      m_count   = '0;
      m_compare = '0;
      m_ticks   = 0;
      m_tp      = 1'b0;
   endtask

   function automatic logic [5:0] m_hw();
      logic [5:0] v;
      v = (s_hist[SYNC-1] & ~MASK) | m_pend;
      if (m_tp) v[TL] = 1'b1;
      return v;
   endfunction

   // Count advances on every second unfrozen cycle since the last reset/write.
   task automatic model_edge();
      logic       inc, match;
      logic [5:0] rise, clr;
      inc   = !count_we && !count_dc && (m_ticks % 2 == 1);
      match = inc && ((m_count + 32'd1) == m_compare);
      if (count_we) begin
         m_count = cop0_wdata;
         m_ticks = 0;
      end else if (!count_dc) begin
         m_ticks++;
         if (inc) m_count = m_count + 32'd1;
      end
      if (compare_we) begin
         m_tp      = 1'b0;
         m_compare = cop0_wdata;
      end else if (match) begin
         m_tp = 1'b1;
      end
      for (int k = 7; k > 0; k--) s_hist[k] = s_hist[k-1];
      s_hist[0] = ext_int_raw;
      rise   = s_hist[SYNC] & ~s_hist[SYNC+1];
      clr    = accept_hardware_interrupt ? ext_int_taken : 6'h00;
      m_pend = ((m_pend & ~clr) | rise) & MASK;
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset_n) model_edge();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      accept_hardware_interrupt = 1'b0;
      ext_int_taken = '0;
      count_dc      = 1'b0;
      count_we      = 1'b0;
      compare_we    = 1'b0;
      cop0_wdata    = '0;
   endtask

   always @(negedge clk) begin
      chk("hw_int", {26'd0, hardware_int}, {26'd0, m_hw()});
      chk("count", count, m_count);
      chk("compare", compare, m_compare);
      chk("timer_pending", {31'd0, timer_pending}, {31'd0, m_tp});
   end

   logic [31:0] snap;

   initial begin
      model_reset();
      // Reset with all pins high.
      ext_int_raw = 6'h3F;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      tick();
      chk("lvl_after_2", {26'd0, hardware_int}, 32'h34);
      chk("count_after_2", count, 32'd1);
      tick();
      chk("all_after_3", {26'd0, hardware_int}, 32'h3F);
      tick();
      chk("count_after_4", count, 32'd2);

      // Edge latch on line 0.
      ext_int_raw = 6'h00;
      repeat (4) tick();
      accept_hardware_interrupt = 1'b1;
      ext_int_taken = 6'h3F;
      tick();
      idle_inputs();
      tick();
      chk("edge_cleared", {31'd0, hardware_int[0]}, 32'd0);
      ext_int_raw[0] = 1'b1;
      tick();
      ext_int_raw[0] = 1'b0;
      tick();
      chk("edge_not_yet", {31'd0, hardware_int[0]}, 32'd0);
      tick();
      chk("edge_set_3rd", {31'd0, hardware_int[0]}, 32'd1);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("edge_hold", {31'd0, hardware_int[0]}, 32'd1);
      end
      accept_hardware_interrupt = 1'b1;
      ext_int_taken = 6'h01;
      tick();
      idle_inputs();
      chk("edge_taken", {31'd0, hardware_int[0]}, 32'd0);
      ext_int_raw[0] = 1'b1;
      tick();
      ext_int_raw[0] = 1'b0;
      tick();
      accept_hardware_interrupt = 1'b1;
      ext_int_taken = 6'h01;
      tick();
      idle_inputs();
      chk("set_beats_clear", {31'd0, hardware_int[0]}, 32'd1);

      // Timer match: compare=5, count=3.
      compare_we = 1'b1; cop0_wdata = 32'd5;
      tick();
      idle_inputs();
      count_we = 1'b1; cop0_wdata = 32'd3;
      tick();
      idle_inputs();
      chk("count_loaded", count, 32'd3);
      repeat (3) tick();
      chk("tp_before_match", {31'd0, timer_pending}, 32'd0);
      tick();
      chk("tp_at_match", {31'd0, timer_pending}, 32'd1);
      chk("hw5_at_match", {31'd0, hardware_int[5]}, 32'd1);
      chk("count_at_match", count, 32'd5);
      compare_we = 1'b1; cop0_wdata = 32'h1000;
      tick();
      idle_inputs();
      chk("tp_cleared", {31'd0, timer_pending}, 32'd0);

      // Wrap with compare = 0.
      compare_we = 1'b1; cop0_wdata = 32'd0;
      tick();
      idle_inputs();
      count_we = 1'b1; cop0_wdata = 32'hFFFF_FFFE;
      tick();
      idle_inputs();
      repeat (2) tick();
      chk("wrap_ffff", count, 32'hFFFF_FFFF);
      chk("wrap_tp0", {31'd0, timer_pending}, 32'd0);
      repeat (2) tick();
      chk("wrap_zero", count, 32'd0);
      chk("wrap_tp1", {31'd0, timer_pending}, 32'd1);

      // Freeze and write priority.
      compare_we = 1'b1; cop0_wdata = 32'h5000;
      tick();
      idle_inputs();
      snap = m_count;
      count_dc = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("frozen", count, snap);
      end
      count_dc = 1'b0;
      count_we = 1'b1; cop0_wdata = 32'd100;
      tick();
      count_we = 1'b0;
      tick();
      count_we = 1'b1; cop0_wdata = 32'd200;
      tick();
      idle_inputs();
      chk("we_over_inc", count, 32'd200);
      repeat (2) tick();
      chk("after_we_inc", count, 32'd201);

      // Compare write on the match cycle.
      compare_we = 1'b1; cop0_wdata = 32'd10;
      tick();
      idle_inputs();
      count_we = 1'b1; cop0_wdata = 32'd8;
      tick();
      idle_inputs();
      repeat (3) tick();
      compare_we = 1'b1; cop0_wdata = 32'd100;
      tick();
      idle_inputs();
      chk("conflict_tp", {31'd0, timer_pending}, 32'd0);
      chk("conflict_cmp", compare, 32'd100);
      chk("conflict_count", count, 32'd10);

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 3) == 0) ext_int_raw = 6'($urandom);
         accept_hardware_interrupt = ($urandom_range(0, 3) == 0);
         ext_int_taken = 6'($urandom);
         count_dc = ($urandom_range(0, 7) == 0);
         count_we = ($urandom_range(0, 39) == 0);
         compare_we = ($urandom_range(0, 29) == 0);
         if (compare_we) cop0_wdata = m_count + $urandom_range(0, 8);
         else if ($urandom_range(0, 3) == 0) cop0_wdata = 32'hFFFF_FFFF - $urandom_range(0, 6);
         else cop0_wdata = $urandom;
         tick();
      end
      idle_inputs();

      // Asynchronous reset mid-operation.
      ext_int_raw = 6'h3F;
      repeat (6) tick();
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("async_hw", {26'd0, hardware_int}, 32'd0);
      chk("async_count", count, 32'd0);
      chk("async_tp", {31'd0, timer_pending}, 32'd0);
      chk("async_cmp", compare, 32'd0);
      tick();
      reset_n = 1'b1;
      repeat (6) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
